// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, serial frame, ACK check).
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled transfer after TIMEOUT_CYCLES.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_CYCLES   = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CW = $clog2(INHIBIT_CYCLES + START_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [9:0]    shift, shift_n;
  logic          clk_oe_n, data_oe_n, done_n, error_n;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          clk_fall;
  logic          accept;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd, wd_n;
`else
  // Watchdog compiled out; TIMEOUT_CYCLES stays declared so existing overrides remain valid.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  // Idle bus level is high, so the synchronizers reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_fall = clk_prev & ~clk_sync[1];
  assign busy     = (state != S_IDLE);
  assign tx_ready = (state == S_IDLE) && !done && !error;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      error       <= error_n;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd <= '0;
    else          wd <= wd_n;
  end
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_n      = (wd == '1) ? wd : wd + 1'b1;
`endif
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_INHIBIT;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          cnt_n     = '0;
          bit_cnt_n = '0;
          shift_n   = {1'b1, ~^tx_data, tx_data};
        end
      end
      S_INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n   = S_START;
          data_oe_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      S_START: begin
        if (cnt == CW'(START_CYCLES - 1)) begin
          state_n   = S_SEND;
          clk_oe_n  = 1'b0;
          bit_cnt_n = '0;
`ifdef PS2_TX_TIMEOUT_EN
          wd_n      = '0;
`endif
        end else begin
          cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      S_SEND: begin
        // Shift in ones so the 10th edge always presents the released stop bit.
        if (clk_fall) begin
          data_oe_n = ~shift[0];
          shift_n   = {1'b1, shift[9:1]};
          bit_cnt_n = (bit_cnt == 4'd10) ? bit_cnt : bit_cnt + 1'b1;
          if (bit_cnt == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          if (!data_sync[1]) begin
            state_n = S_WAIT_IDLE;
          end else begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync[1] && data_sync[1]) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if ((state == S_SEND || state == S_ACK || state == S_WAIT_IDLE) &&
        wd == WW'(TIMEOUT_CYCLES - 1)) begin
      state_n   = S_IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      done_n    = 1'b0;
      error_n   = 1'b1;
    end
`endif
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the CPU memory-mapped I/O path to the keyboard over the shared open-drain PS/2 clock/data lines, the reverse direction of the existing `ps2` receiver. It sits beside `ps2` in `jpeb`. It runs the bus inhibit, request-to-send, bit-serial transmit, parity, stop bit and device-ACK check. It asserts `busy` so the receiver ignores the bus during a transfer.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 5000 — clk cycles the PS/2 clock is held low before the request (100 µs at 50 MHz).
- `START_CYCLES`, 100 — clk cycles data is held low with clock still low before clock release.
- `TIMEOUT_CYCLES`, 1000000 — max clk cycles from clock release to ACK completion (20 ms); used only with the timeout macro.

Ports:
- `clk` in 1 — system clock (50 MHz).
- `reset_n` in 1 — asynchronous, active-low reset.
- `tx_valid` in 1 — request to send `tx_data`.
- `tx_data` in 8 — command byte.
- `tx_ready` out 1 — idle, accepting a request.
- `done` out 1 — one-cycle pulse: byte sent and ACKed.
- `error` out 1 — one-cycle pulse: NACK or timeout.
- `busy` out 1 — transfer in progress; receiver must discard bits.
- `ps2_clk_in` in 1 — raw PS/2 clock pin level.
- `ps2_data_in` in 1 — raw PS/2 data pin level.
- `ps2_clk_oe` out 1 — 1 = drive PS/2 clock low, 0 = release.
- `ps2_data_oe` out 1 — 1 = drive PS/2 data low, 0 = release.

## Operation
- Both pins pass through 2-FF synchronizers. A falling edge is synchronized clock 1→0 between consecutive cycles.
- Accept: `tx_valid && tx_ready`. This latches `{stop=1, parity=~^tx_data, tx_data}` into a 10-bit shift register, LSB first.
- IDLE: both oe 0, `tx_ready`=1, `busy`=0. On accept go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES, then go to START.
- START: `ps2_data_oe`=1 (start bit 0), clock still held, for START_CYCLES. Then release clock and go to SEND with the bit count at 0.
- SEND: on each falling edge, `ps2_data_oe` = ~shift[0], shift right, increment the count. Falling edges 1–8 present data bits 0–7, edge 9 presents parity, and edge 10 presents stop (data released). After edge 10 go to ACK.
- ACK: on the next falling edge (11th), sample synchronized data. 0 goes to WAIT_IDLE. 1 raises `error` and goes to IDLE.
- WAIT_IDLE: when both synchronized lines are high, pulse `done` and return to IDLE.
- `tx_valid` while not ready is ignored; there is no queueing.
- Pulse and transition cycle: `done`/`error` is asserted in the same cycle the FSM enters IDLE. `tx_ready` rises the cycle after.

## Timing
- Reset values: `tx_ready`=1, `done`=0, `error`=0, `busy`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0, all counters 0, FSM state IDLE.
- Reset mid-transfer releases both lines immediately (async) and drops the transfer with no `done` or `error`.
- `busy` rises the cycle after accept and falls with the `done` or `error` pulse.
- `ps2_clk_oe` is high for exactly INHIBIT_CYCLES+START_CYCLES cycles. `ps2_data_oe` rises exactly INHIBIT_CYCLES cycles after accept.
- Data output updates 3 clk cycles after a raw PS/2 clock falling edge (2 sync + 1 register). This is well inside the device's ≥5 µs low phase.
- The counter saturates and never wraps; the bit count never exceeds 10.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counts from clock release.
  - Reaching TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE releases both lines, pulses `error` and returns to IDLE.
- Undefined:
  - No watchdog logic.
  - The FSM waits indefinitely for device clocks.

## Test plan
(Bench uses INHIBIT_CYCLES=20, START_CYCLES=4, TIMEOUT_CYCLES=2000. The device model clocks at 1/40 clk, changes levels mid-high, and ACKs on the 11th clock.)

- Send 0xED → bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1. The ACK is taken, `done` pulses once, and `error` stays 0.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Both end with `done` pulsing.
- Inhibit timing: accept 0xF4 → `ps2_clk_oe` high 24 cycles, `ps2_data_oe` rises at cycle 20, `tx_ready` low throughout.
- Device withholds ACK (data high on the 11th edge) → `error` pulses, `done` stays 0, then `tx_ready`=1.
- With `PS2_TX_TIMEOUT_EN`, the device never clocks → `error` pulses 2000 cycles after clock release and both oe are 0. Without the macro, the FSM stays in SEND.
- Reset: assert `reset_n`=0 at bit 4 of 0xFF → both oe drop asynchronously and `tx_ready`=1 after release. A subsequent 0xFF completes normally.
